video_timing_gen: RTL and testbench

Parametrised raster timing generator for arcade cores. It produces pixel position, blanking and active-low syncs from a pixel clock-enable in the system clock domain. It replaces per-core hard-coded timing counters. It adds a runtime-selectable vertical mode, frame-boundary mode switching, a vblank-start pulse, a frame counter, and blanked, registered RGB pass-through. It sits between the game core (which consumes hpos/vpos) and arcade_video.

---
 rtl/video_timing_gen_if.sv | 42 ++++
 rtl/video_timing_gen.sv | 179 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle for video_timing_gen: enables, mode and colour in, raster position/flags/colour out.
// VTG_POS_ADJ_EN adds the h_adj/v_adj sync-centring inputs.
interface video_timing_gen_if #(
    parameter int HW = 9,
    parameter int VW = 9,
    parameter int CW = 12
);
    logic          ce_pix;
    logic          mode;
    logic [CW-1:0] rgb_in;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          hblank;
    logic          vblank;
    logic          hs_n;
    logic          vs_n;
    logic          vbl_start;
    logic [7:0]    frame_cnt;
    logic [CW-1:0] rgb_out;
`ifdef VTG_POS_ADJ_EN
    logic signed [3:0] h_adj;
    logic signed [2:0] v_adj;

    modport master (
        input  ce_pix, mode, rgb_in, h_adj, v_adj,
        output hpos, vpos, hblank, vblank, hs_n, vs_n, vbl_start, frame_cnt, rgb_out
    );
    modport slave (
        output ce_pix, mode, rgb_in, h_adj, v_adj,
        input  hpos, vpos, hblank, vblank, hs_n, vs_n, vbl_start, frame_cnt, rgb_out
    );
`else
    modport master (
        input  ce_pix, mode, rgb_in,
        output hpos, vpos, hblank, vblank, hs_n, vs_n, vbl_start, frame_cnt, rgb_out
    );
    modport slave (
        output ce_pix, mode, rgb_in,
        input  hpos, vpos, hblank, vblank, hs_n, vs_n, vbl_start, frame_cnt, rgb_out
    );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, registered blanking/sync flags, vblank-start pulse, frame counter
// and blanked RGB pass-through. Optional VTG_POS_ADJ_EN adds per-frame sync position adjustment.
module video_timing_gen #(
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int CW           = 12,
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_START  = 16,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 312,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACT_START  = 16,
    parameter int V_ACTIVE0    = 192,
    parameter int V_ACTIVE1    = 224,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_LEN   = 8
) (
    input  logic               clk_sys,
    input  logic               reset,
    video_timing_gen_if.master vid
);

`ifdef VTG_POS_ADJ_EN
    localparam int H_ADJ_MIN = -8;
    localparam int H_ADJ_MAX = 7;
    localparam int V_ADJ_MIN = -4;
    localparam int V_ADJ_MAX = 3;
`else
    localparam int H_ADJ_MIN = 0;
    localparam int H_ADJ_MAX = 0;
    localparam int V_ADJ_MIN = 0;
    localparam int V_ADJ_MAX = 0;
`endif
    localparam int V_ACT_MAX = (V_ACTIVE0 > V_ACTIVE1) ? V_ACTIVE0 : V_ACTIVE1;

    generate
        if (H_ACT_START + H_ACTIVE > H_SYNC_START + H_ADJ_MIN) begin : g_err_h_act
            $error("video_timing_gen: horizontal active area overlaps sync window");
        end
        if (H_SYNC_START + H_ADJ_MAX + H_SYNC_LEN > H_TOTAL) begin : g_err_h_sync
            $error("video_timing_gen: horizontal sync runs past H_TOTAL");
        end
        if (V_ACT_START + V_ACT_MAX > V_SYNC_START + V_ADJ_MIN) begin : g_err_v_act
            $error("video_timing_gen: vertical active area overlaps sync window");
        end
        if (V_SYNC_START + V_ADJ_MAX + V_SYNC_LEN > V_TOTAL) begin : g_err_v_sync
            $error("video_timing_gen: vertical sync runs past V_TOTAL");
        end
        if (H_TOTAL > (1 << HW)) begin : g_err_hw
            $error("video_timing_gen: H_TOTAL does not fit in HW bits");
        end
        if (V_TOTAL > (1 << VW)) begin : g_err_vw
            $error("video_timing_gen: V_TOTAL does not fit in VW bits");
        end
    endgenerate

    // Comparisons run one bit wider so window ends equal to 2^HW / 2^VW stay representable.
    localparam logic [HW:0] L_H_LAST       = (HW+1)'(H_TOTAL - 1);
    localparam logic [HW:0] L_H_ACT_LO     = (HW+1)'(H_ACT_START);
    localparam logic [HW:0] L_H_ACT_HI     = (HW+1)'(H_ACT_START + H_ACTIVE);
    localparam logic [HW:0] L_H_SYNC_START = (HW+1)'(H_SYNC_START);
    localparam logic [HW:0] L_H_SYNC_LEN   = (HW+1)'(H_SYNC_LEN);
    localparam logic [VW:0] L_V_LAST       = (VW+1)'(V_TOTAL - 1);
    localparam logic [VW:0] L_V_ACT_LO     = (VW+1)'(V_ACT_START);
    localparam logic [VW:0] L_V_ACT_HI0    = (VW+1)'(V_ACT_START + V_ACTIVE0);
    localparam logic [VW:0] L_V_ACT_HI1    = (VW+1)'(V_ACT_START + V_ACTIVE1);
    localparam logic [VW:0] L_V_SYNC_START = (VW+1)'(V_SYNC_START);
    localparam logic [VW:0] L_V_SYNC_LEN   = (VW+1)'(V_SYNC_LEN);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_mode_q;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_hs_n;
    logic          r_vs_n;
    logic          r_vbl_start;
    logic [7:0]    r_frame_cnt;
    logic [CW-1:0] r_rgb_out;

    logic          w_line_end;
    logic          w_frame_end;
    logic [HW-1:0] w_hcnt_next;
    logic [VW-1:0] w_vcnt_next;
    logic [HW:0]   w_hn;
    logic [VW:0]   w_vn;
    logic          w_mode_next;
    logic [VW:0]   w_v_act_hi;
    logic [HW:0]   w_hss_next;
    logic [VW:0]   w_vss_next;
    logic          w_hblank_next;
    logic          w_vblank_next;
    logic          w_hs_n_next;
    logic          w_vs_n_next;
    logic          w_vbl_start_next;

    assign w_line_end  = ({1'b0, r_hcnt} == L_H_LAST);
    assign w_frame_end = w_line_end && ({1'b0, r_vcnt} == L_V_LAST);
    assign w_hcnt_next = w_line_end ? '0 : r_hcnt + HW'(1);
    assign w_vcnt_next = w_frame_end ? '0 : (w_line_end ? r_vcnt + VW'(1) : r_vcnt);
    assign w_hn        = {1'b0, w_hcnt_next};
    assign w_vn        = {1'b0, w_vcnt_next};

    // Frame geometry is only allowed to change on the ce_pix that lands on (0,0).
    assign w_mode_next = w_frame_end ? vid.mode : r_mode_q;
    assign w_v_act_hi  = w_mode_next ? L_V_ACT_HI1 : L_V_ACT_HI0;

`ifdef VTG_POS_ADJ_EN
    logic [HW:0] r_hss;
    logic [VW:0] r_vss;
    logic [HW:0] w_hss_load;
    logic [VW:0] w_vss_load;

    assign w_hss_load = L_H_SYNC_START + {{(HW-3){vid.h_adj[3]}}, vid.h_adj};
    assign w_vss_load = L_V_SYNC_START + {{(VW-2){vid.v_adj[2]}}, vid.v_adj};
    assign w_hss_next = w_frame_end ? w_hss_load : r_hss;
    assign w_vss_next = w_frame_end ? w_vss_load : r_vss;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hss <= w_hss_load;
            r_vss <= w_vss_load;
        end else if (vid.ce_pix) begin
            r_hss <= w_hss_next;
            r_vss <= w_vss_next;
        end
    end
`else
    assign w_hss_next = L_H_SYNC_START;
    assign w_vss_next = L_V_SYNC_START;
`endif

    assign w_hblank_next    = !((w_hn >= L_H_ACT_LO) && (w_hn < L_H_ACT_HI));
    assign w_vblank_next    = !((w_vn >= L_V_ACT_LO) && (w_vn < w_v_act_hi));
    assign w_hs_n_next      = !((w_hn >= w_hss_next) && (w_hn < w_hss_next + L_H_SYNC_LEN));
    assign w_vs_n_next      = !((w_vn >= w_vss_next) && (w_vn < w_vss_next + L_V_SYNC_LEN));
    assign w_vbl_start_next = (w_vn == w_v_act_hi) && (w_hcnt_next == '0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_mode_q    <= vid.mode;
            r_hblank    <= 1'b1;
            r_vblank    <= 1'b1;
            r_hs_n      <= 1'b1;
            r_vs_n      <= 1'b1;
            r_vbl_start <= 1'b0;
            r_frame_cnt <= '0;
            r_rgb_out   <= '0;
        end else if (vid.ce_pix) begin
            r_hcnt      <= w_hcnt_next;
            r_vcnt      <= w_vcnt_next;
            r_mode_q    <= w_mode_next;
            r_hblank    <= w_hblank_next;
            r_vblank    <= w_vblank_next;
            r_hs_n      <= w_hs_n_next;
            r_vs_n      <= w_vs_n_next;
            r_vbl_start <= w_vbl_start_next;
            r_frame_cnt <= w_frame_end ? r_frame_cnt + 8'd1 : r_frame_cnt;
            // Blanking decision uses the flags of the pixel whose colour is arriving now.
            r_rgb_out   <= (r_hblank || r_vblank) ? '0 : vid.rgb_in;
        end else begin
            r_vbl_start <= 1'b0;
        end
    end

    assign vid.hpos      = r_hcnt - HW'(H_ACT_START);
    assign vid.vpos      = r_vcnt - VW'(V_ACT_START);
    assign vid.hblank    = r_hblank;
    assign vid.vblank    = r_vblank;
    assign vid.hs_n      = r_hs_n;
    assign vid.vs_n      = r_vs_n;
    assign vid.vbl_start = r_vbl_start;
    assign vid.frame_cnt = r_frame_cnt;
    assign vid.rgb_out   = r_rgb_out;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default horizontal timing, shortened vertical timing so
// several whole frames fit in a short run.
`timescale 1ns/1ps
module tb_video_timing_gen;
    localparam int HW = 9;
    localparam int VW = 9;
    localparam int CW = 12;
    localparam int H_TOTAL = 384;
    localparam int H_ACT_START = 16;
    localparam int V_TOTAL = 28;
    localparam int V_ACT_START = 2;
    localparam int FRAME = H_TOTAL * V_TOTAL;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    int   tb_h = 0;
    int   tb_v = 0;

    video_timing_gen_if #(.HW(HW), .VW(VW), .CW(CW)) vif ();

    video_timing_gen #(
        .HW(HW), .VW(VW), .CW(CW),
        .H_TOTAL(H_TOTAL), .H_ACT_START(H_ACT_START), .H_ACTIVE(256),
        .H_SYNC_START(312), .H_SYNC_LEN(32),
        .V_TOTAL(V_TOTAL), .V_ACT_START(V_ACT_START), .V_ACTIVE0(12), .V_ACTIVE1(16),
        .V_SYNC_START(22), .V_SYNC_LEN(2)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .vid(vif)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s (h=%0d v=%0d): got 0x%0h, expected 0x%0h", $time, tag, tb_h, tb_v, obs, exp);
        end else begin
            $display("[%0t] ok   %s (h=%0d v=%0d): 0x%0h", $time, tag, tb_h, tb_v, obs);
        end
    endtask

    function automatic logic [31:0] hp(input int h);
        return 32'((h - H_ACT_START) & ((1 << HW) - 1));
    endfunction

    function automatic logic [31:0] vp(input int v);
        return 32'((v - V_ACT_START) & ((1 << VW) - 1));
    endfunction

    // One clk_sys edge; the reference position follows enabled edges only.
    task automatic tick();
        @(posedge clk_sys);
        if (reset) begin
            tb_h = 0;
            tb_v = 0;
        end else if (vif.ce_pix) begin
            if (tb_h == H_TOTAL - 1) begin
                tb_h = 0;
                tb_v = (tb_v == V_TOTAL - 1) ? 0 : tb_v + 1;
            end else begin
                tb_h = tb_h + 1;
            end
        end
        #1;
    endtask

    task automatic goto_pos(input int h, input int v);
        int d;
        vif.ce_pix = 1'b1;
        d = ((v * H_TOTAL + h) - (tb_v * H_TOTAL + tb_h) + FRAME) % FRAME;
        repeat (d) tick();
    endtask

    task automatic check_reset_state();
        check("rst_hpos", 32'(vif.hpos), hp(0));
        check("rst_vpos", 32'(vif.vpos), vp(0));
        check("rst_hblank", 32'(vif.hblank), 1);
        check("rst_vblank", 32'(vif.vblank), 1);
        check("rst_hs_n", 32'(vif.hs_n), 1);
        check("rst_vs_n", 32'(vif.vs_n), 1);
        check("rst_vbl_start", 32'(vif.vbl_start), 0);
        check("rst_frame_cnt", 32'(vif.frame_cnt), 0);
        check("rst_rgb_out", 32'(vif.rgb_out), 0);
    endtask

    initial begin
        reset = 1'b1;
        vif.ce_pix = 1'b1;
        vif.mode = 1'b0;
        vif.rgb_in = 12'hABC;
`ifdef VTG_POS_ADJ_EN
        vif.h_adj = 4'sd0;
        vif.v_adj = 3'sd0;
`endif
        repeat (3) tick();
        check_reset_state();
        check("rst_hpos_raw", 32'(vif.hpos), 32'h1F0);
        reset = 1'b0;

        // Horizontal edges.
        goto_pos(15, 0);  check("hblank_h15", 32'(vif.hblank), 1); check("hpos_h15", 32'(vif.hpos), 32'h1FF);
        goto_pos(16, 0);  check("hblank_h16", 32'(vif.hblank), 0); check("hpos_h16", 32'(vif.hpos), 0);
        goto_pos(271, 0); check("hblank_h271", 32'(vif.hblank), 0);
        goto_pos(272, 0); check("hblank_h272", 32'(vif.hblank), 1);
        goto_pos(311, 0); check("hs_n_h311", 32'(vif.hs_n), 1);
        goto_pos(312, 0); check("hs_n_h312", 32'(vif.hs_n), 0);
        goto_pos(343, 0); check("hs_n_h343", 32'(vif.hs_n), 0);
        goto_pos(344, 0); check("hs_n_h344", 32'(vif.hs_n), 1);
        goto_pos(0, 1);   check("hpos_wrap", 32'(vif.hpos), 32'h1F0); check("vpos_v1", 32'(vif.vpos), 32'h1FF);
        goto_pos(16, 1);  check("hblank_l1_h16", 32'(vif.hblank), 0);

        // Mode 0 frame: active lines 2..13, pulse at line 14, vsync lines 22..23.
        goto_pos(383, 1);  check("vblank_v1", 32'(vif.vblank), 1);
        goto_pos(0, 2);    check("vblank_v2", 32'(vif.vblank), 0); check("vpos_v2", 32'(vif.vpos), 0);
        goto_pos(383, 13); check("vblank_v13", 32'(vif.vblank), 0); check("vbl_v13", 32'(vif.vbl_start), 0);
        goto_pos(0, 14);   check("vblank_v14", 32'(vif.vblank), 1); check("vbl_v14", 32'(vif.vbl_start), 1);
        goto_pos(1, 14);   check("vbl_v14_h1", 32'(vif.vbl_start), 0);
        goto_pos(383, 21); check("vs_n_v21", 32'(vif.vs_n), 1);
        goto_pos(0, 22);   check("vs_n_v22", 32'(vif.vs_n), 0);
        goto_pos(383, 23); check("vs_n_v23", 32'(vif.vs_n), 0);
        goto_pos(0, 24);   check("vs_n_v24", 32'(vif.vs_n), 1);
        goto_pos(383, 27); check("frame_cnt_pre", 32'(vif.frame_cnt), 0);
        goto_pos(0, 0);    check("frame_cnt_1", 32'(vif.frame_cnt), 1);

        // Mode change mid-frame applies from the next frame.
        goto_pos(0, 8);
        vif.mode = 1'b1;
        goto_pos(383, 13); check("m1pend_vblank_v13", 32'(vif.vblank), 0);
        goto_pos(0, 14);   check("m1pend_vblank_v14", 32'(vif.vblank), 1); check("m1pend_vbl_v14", 32'(vif.vbl_start), 1);
        goto_pos(0, 0);    check("frame_cnt_2", 32'(vif.frame_cnt), 2);
        goto_pos(0, 14);   check("m1_vblank_v14", 32'(vif.vblank), 0); check("m1_vbl_v14", 32'(vif.vbl_start), 0);
        goto_pos(383, 17); check("m1_vblank_v17", 32'(vif.vblank), 0);
        goto_pos(0, 18);   check("m1_vblank_v18", 32'(vif.vblank), 1); check("m1_vbl_v18", 32'(vif.vbl_start), 1);

        // RGB pass-through, one pixel behind hpos, zero while blanked.
        goto_pos(16, 5);  check("rgb_h16", 32'(vif.rgb_out), 0);
        goto_pos(17, 5);  check("rgb_h17", 32'(vif.rgb_out), 32'hABC);
        goto_pos(100, 5);
        vif.rgb_in = 12'h123;
        goto_pos(101, 5); check("rgb_h101", 32'(vif.rgb_out), 32'h123);
        goto_pos(272, 5); check("rgb_h272", 32'(vif.rgb_out), 32'h123); check("hblank_rgb_h272", 32'(vif.hblank), 1);
        goto_pos(273, 5); check("rgb_h273", 32'(vif.rgb_out), 0);
        goto_pos(100, 20); check("rgb_vblank", 32'(vif.rgb_out), 0);

        // ce_pix one clk_sys in four around the vblank pulse.
        goto_pos(383, 17); check("ce4_hpos_a", 32'(vif.hpos), hp(383));
        vif.ce_pix = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce4_hold_hpos", 32'(vif.hpos), hp(383));
            check("ce4_hold_vbl0", 32'(vif.vbl_start), 0);
        end
        vif.ce_pix = 1'b1; tick();
        check("ce4_vbl_pulse", 32'(vif.vbl_start), 1); check("ce4_vpos", 32'(vif.vpos), vp(18));
        vif.ce_pix = 1'b0; tick();
        check("ce4_vbl_off", 32'(vif.vbl_start), 0); check("ce4_vblank_hold", 32'(vif.vblank), 1);
        check("ce4_hpos_hold", 32'(vif.hpos), hp(0));
        repeat (2) tick();
        check("ce4_hpos_hold2", 32'(vif.hpos), hp(0));
        vif.ce_pix = 1'b1; tick();
        check("ce4_hpos_step", 32'(vif.hpos), hp(1)); check("ce4_vbl_step", 32'(vif.vbl_start), 0);

        // Reset mid-frame; mode sampled during reset sets the next frame's geometry.
        goto_pos(200, 10);
        check("pre_rst_rgb", 32'(vif.rgb_out), 32'h123);
        check("pre_rst_frame_cnt", 32'(vif.frame_cnt), 5);
        vif.mode = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        tick();
        check("post_rst_vbl", 32'(vif.vbl_start), 0);
        check("post_rst_hpos", 32'(vif.hpos), hp(1));
        goto_pos(0, 14);
        check("post_rst_vbl_v14", 32'(vif.vbl_start), 1);
        check("post_rst_frame_cnt", 32'(vif.frame_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
